// File: rtl/rr_datapath_arbiter.sv
// rtl/rr_datapath_arbiter.sv - round-robin burst arbiter onto one shared datapath
// Optional feature macro: ARB_BURST_LIMIT_EN (caps each grant at MAX_BEATS transfers)

module rr_datapath_muxn #(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]   sel,
  input  logic [NREQ*N-1:0] din,
  output logic [N-1:0]      dout
);
  // One-hot AND-OR select: an all-zero select yields zero, so idle never leaks data.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) dout = dout | din[i*N +: N];
    end
  end
endmodule

module rr_datapath_arbiter #(
  parameter int N         = 32,
  parameter int NREQ      = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [NREQ*N-1:0] data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  if (NREQ < 2 || NREQ > 8 || MAX_BEATS < 1) begin : g_bad_param
    $error("rr_datapath_arbiter: NREQ must be 2..8 and MAX_BEATS >= 1");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [PW-1:0]   ptr, ptr_nxt, own, own_nxt;
  logic [PW-1:0]   off, pick, own_inc;
  logic [PW:0]     sum;
  logic [NREQ-1:0] rot;
  logic            found;
  logic            xfer, release_g, limit_hit;

  // Rotate requests so the search always starts at ptr; lowest set bit wins.
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (rot[j]) begin
        off   = PW'(j);
        found = 1'b1;
      end
    end
  end

  assign sum     = {1'b0, ptr} + {1'b0, off};
  assign pick    = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : sum[PW-1:0];
  assign own_inc = (own == PW'(NREQ-1)) ? '0 : own + 1'b1;

  rr_datapath_muxn #(.N(N), .NREQ(NREQ)) u_mux (
    .sel  (grant),
    .din  (data),
    .dout (out_data)
  );

  assign busy      = (state == OWN);
  assign out_valid = |(req & grant);
  assign out_last  = |(last & grant) | (limit_hit & busy);
  assign req_ready = grant & {NREQ{out_ready}};
  assign xfer      = out_valid & out_ready;
  assign release_g = xfer & out_last;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BEATS) + 1;
  logic [CW-1:0] beats;

  assign limit_hit = (beats == CW'(MAX_BEATS-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              beats <= '0;
    else if (state == IDLE) beats <= '0;
    else if (xfer)          beats <= beats + 1'b1;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    own_nxt   = own;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = OWN;
          grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          own_nxt   = pick;
        end
      end
      OWN: begin
        if (release_g) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = own_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      own   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
      own   <= own_nxt;
    end
  end
endmodule

// File: tb/tb_rr_datapath_arbiter.sv
// tb/tb_rr_datapath_arbiter.sv - self-checking bench for rr_datapath_arbiter
// Build with +define+ARB_BURST_LIMIT_EN to also exercise the burst cap (MAX_BEATS=4).

module tb_rr_datapath_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam int MAXB  = 4;
  localparam bit LIMIT = 1'b1;
`else
  localparam int MAXB  = 8;
  localparam bit LIMIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, last, req_ready, grant;
  logic [NREQ*N-1:0] data;
  logic              out_valid, out_last, out_ready, busy;
  logic [N-1:0]      out_data;

  int tests = 0;
  int fails = 0;

  // Reference state: current owner (-1 when idle), round-robin start, beats this grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  rr_datapath_arbiter #(.N(N), .NREQ(NREQ), .MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .data      (data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ*N-1:0] mkdata(input int sel, input logic [N-1:0] v);
    logic [NREQ*N-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*N +: N] = (i == sel) ? v : (32'hDEAD_0000 + N'(i));
    return d;
  endfunction

  task automatic cmp_model(input string tag);
    logic [NREQ-1:0] eg;
    logic            ev, el;
    logic [N-1:0]    ed;
    logic [NREQ-1:0] sh;
    eg = '0; ev = 1'b0; el = 1'b0; ed = '0;
    if (!reset && m_owner >= 0) begin
      eg = NREQ'(1) << m_owner;
      sh = req >> m_owner;
      ev = sh[0];
      sh = last >> m_owner;
      el = sh[0] || (LIMIT && m_cnt == MAXB-1);
      ed = N'(data >> (m_owner*N));
    end
    chk({tag, ".grant"},     grant,     eg);
    chk({tag, ".out_valid"}, out_valid, ev);
    chk({tag, ".out_data"},  out_data,  ed);
    chk({tag, ".out_last"},  out_last,  el);
    chk({tag, ".req_ready"}, req_ready, eg & {NREQ{out_ready}});
    chk({tag, ".busy"},      busy,      eg != 0);
  endtask

  task automatic model_step();
    logic [NREQ-1:0] sh;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        sh = req >> ((m_ptr + k) % NREQ);
        if (sh[0]) begin
          m_owner = (m_ptr + k) % NREQ;
          m_cnt   = 0;
          break;
        end
      end
    end else begin
      sh = req >> m_owner;
      if (sh[0] && out_ready) begin
        m_cnt++;
        sh = last >> m_owner;
        if (sh[0] || (LIMIT && m_cnt == MAXB)) begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 ns later, well clear of posedge.
  task automatic cycle(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] lst,
                       input logic rdy, input logic [NREQ*N-1:0] d, input string tag);
    @(negedge clk);
    reset = r; req = rq; last = lst; out_ready = rdy; data = d;
    #1;
    cmp_model(tag);
    model_step();
  endtask

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] g;
    logic            v;
    logic [N-1:0]    d;
    logic            b;
  } vec_t;

  vec_t tbl[12];
  logic [NREQ*N-1:0] dconst;

  initial begin
    int sent0, sent1;
    int order[$];
    int exp_order[$];

    dconst = {32'h103, 32'h102, 32'h101, 32'h100};
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 1'b0, 32'h0,   1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 1'b0, 32'h0,   1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'h0, 1'b0, 32'h0,   1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'h1, 1'b1, 32'h100, 1'b1};
    tbl[4]  = '{1'b0, 4'hF, 4'h0, 1'b0, 32'h0,   1'b0};
    tbl[5]  = '{1'b0, 4'hF, 4'h2, 1'b1, 32'h101, 1'b1};
    tbl[6]  = '{1'b0, 4'hF, 4'h0, 1'b0, 32'h0,   1'b0};
    tbl[7]  = '{1'b0, 4'hF, 4'h4, 1'b1, 32'h102, 1'b1};
    tbl[8]  = '{1'b0, 4'hF, 4'h0, 1'b0, 32'h0,   1'b0};
    tbl[9]  = '{1'b0, 4'hF, 4'h8, 1'b1, 32'h103, 1'b1};
    tbl[10] = '{1'b0, 4'hF, 4'h0, 1'b0, 32'h0,   1'b0};
    tbl[11] = '{1'b0, 4'hF, 4'h1, 1'b1, 32'h100, 1'b1};

    reset = 1'b1; req = '0; last = '0; out_ready = 1'b0; data = '0;

    // Reset values, then round robin with single-beat bursts from everyone.
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rst, tbl[i].rq, 4'hF, 1'b1, dconst, "rr");
      chk($sformatf("tbl%0d.grant", i),     grant,     tbl[i].g);
      chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].v);
      chk($sformatf("tbl%0d.out_data", i),  out_data,  tbl[i].d);
      chk($sformatf("tbl%0d.busy", i),      busy,      tbl[i].b);
    end

    // Single 3-beat burst from requester 2, then ptr must point at 3.
    cycle(1'b1, 4'h0, 4'h0, 1'b1, '0, "sb");
    cycle(1'b0, 4'h4, 4'h0, 1'b1, mkdata(2, 32'hA), "sb");
    chk("sb.idle_grant", grant, 4'h0);
    cycle(1'b0, 4'h4, 4'h0, 1'b1, mkdata(2, 32'hA), "sb");
    chk("sb.beatA", out_data, 32'hA);
    chk("sb.grantA", grant, 4'h4);
    cycle(1'b0, 4'h4, 4'h0, 1'b1, mkdata(2, 32'hB), "sb");
    chk("sb.beatB", out_data, 32'hB);
    cycle(1'b0, 4'h4, 4'h4, 1'b1, mkdata(2, 32'hC), "sb");
    chk("sb.beatC", out_data, 32'hC);
    chk("sb.lastC", out_last, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1, mkdata(2, 32'hC), "sb");
    chk("sb.released", grant, 4'h0);
    cycle(1'b0, 4'hF, 4'hF, 1'b1, dconst, "sb");
    cycle(1'b0, 4'hF, 4'hF, 1'b1, dconst, "sb");
    chk("sb.ptr3", grant, 4'h8);

    // Backpressure on owner 1.
    cycle(1'b1, 4'h0, 4'h0, 1'b1, '0, "bp");
    cycle(1'b0, 4'h2, 4'h0, 1'b1, mkdata(1, 32'h11), "bp");
    cycle(1'b0, 4'h2, 4'h0, 1'b1, mkdata(1, 32'h11), "bp");
    chk("bp.first_ready", req_ready, 4'h2);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'h2, 4'h0, 1'b0, mkdata(1, 32'h22), "bp");
      chk("bp.stall_data", out_data, 32'h22);
      chk("bp.stall_ready", req_ready, 4'h0);
      chk("bp.stall_grant", grant, 4'h2);
    end
    cycle(1'b0, 4'h2, 4'h2, 1'b1, mkdata(1, 32'h22), "bp");
    chk("bp.resume_ready", req_ready, 4'h2);
    cycle(1'b0, 4'h0, 4'h0, 1'b1, '0, "bp");
    chk("bp.done", grant, 4'h0);

    // Asynchronous reset during beat 2 of a burst from requester 3.
    cycle(1'b1, 4'h0, 4'h0, 1'b1, '0, "rm");
    cycle(1'b0, 4'h8, 4'h0, 1'b1, mkdata(3, 32'h1), "rm");
    cycle(1'b0, 4'h8, 4'h0, 1'b1, mkdata(3, 32'h1), "rm");
    chk("rm.beat1", grant, 4'h8);
    cycle(1'b1, 4'h8, 4'h0, 1'b1, mkdata(3, 32'h2), "rm");
    chk("rm.async_grant", grant, 4'h0);
    chk("rm.async_valid", out_valid, 1'b0);
    cycle(1'b1, 4'h9, 4'h9, 1'b1, dconst, "rm");
    cycle(1'b0, 4'h9, 4'h9, 1'b1, dconst, "rm");
    cycle(1'b0, 4'h9, 4'h9, 1'b1, dconst, "rm");
    chk("rm.req0_first", grant, 4'h1);

`ifdef ARB_BURST_LIMIT_EN
    // 6-beat burst from requester 0 is split 4 + 2 around requester 1's turn.
    cycle(1'b1, 4'h0, 4'h0, 1'b1, '0, "lim");
    sent0 = 0; sent1 = 0;
    exp_order = '{0, 0, 0, 0, 1, 0, 0};
    for (int c = 0; c < 30 && (sent0 < 6 || sent1 < 1); c++) begin
      int who;
      who = m_owner;
      cycle(1'b0, {2'b00, sent1 < 1, sent0 < 6}, {2'b00, 1'b1, sent0 == 5}, 1'b1, dconst, "lim");
      if (who == 0 && sent0 < 6) begin
        sent0++;
        order.push_back(0);
        if (sent0 == 4) chk("lim.beat4_last", out_last, 1'b1);
      end else if (who == 1 && sent1 < 1) begin
        sent1++;
        order.push_back(1);
      end
    end
    chk("lim.sent0", sent0, 6);
    chk("lim.sent1", sent1, 1);
    chk("lim.order_len", order.size(), exp_order.size());
    for (int i = 0; i < order.size() && i < exp_order.size(); i++)
      chk($sformatf("lim.order%0d", i), order[i], exp_order[i]);
`endif

    // Randomized traffic against the reference model.
    cycle(1'b1, 4'h0, 4'h0, 1'b1, '0, "rnd");
    for (int c = 0; c < 600; c++) begin
      logic [NREQ*N-1:0] d;
      for (int i = 0; i < NREQ; i++) d[i*N +: N] = $urandom;
      cycle($urandom_range(0, 59) == 0, NREQ'($urandom), NREQ'($urandom) & NREQ'($urandom),
            $urandom_range(0, 3) != 0, d, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
